frame_event_scheduler: RTL

Per-channel frame-based event scheduler for the game logic. It detects the vsync rising edge once in the pixel-clock domain and shares that frame tick among CHANNELS independent requesters (duck wing flap, dog animation, shot flash, round timer). Each requester starts a channel with a period in frames and an event count. The block then emits single-cycle `tick` pulses every `period` frames and a `done` pulse with the final tick. All outputs are synchronous pulses; no derived clocks are generated.

---
 rtl/frame_event_scheduler.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/frame_event_scheduler.sv
// ---------------------------------------------------------------------------
// frame_event_scheduler
//
// Finds the rising edge of vsync once and turns it into a one-cycle
// frame_tick. CHANNELS independent requesters use that shared tick. A start
// request loads a channel with a period in frames and an event count. The
// channel then pulses tick every `period` frames. It pulses done together
// with the final tick. A count of zero runs the channel until stop. A period
// of zero is treated as one.
//
// Ports
//   pclk        in   pixel clock (only clock)
//   rst_n       in   synchronous active-low reset
//   vsync       in   vertical sync, already synchronous to pclk
//   start       in   [CHANNELS] per-channel start / restart pulse
//   stop        in   [CHANNELS] per-channel abort pulse (highest priority)
//   period      in   [CHANNELS*PERIOD_W] packed periods, sampled on start
//   count       in   [CHANNELS*COUNT_W] packed event counts, sampled on start
//   frame_tick  out  one-cycle pulse per vsync rising edge
//   tick        out  [CHANNELS] one-cycle event pulse
//   done        out  [CHANNELS] one-cycle pulse with a channel's final tick
//   busy        out  [CHANNELS] channel is running
// ---------------------------------------------------------------------------
module frame_event_scheduler #(
    parameter int CHANNELS = 4,
    parameter int PERIOD_W = 8,
    parameter int COUNT_W  = 8
) (
    input  logic                         pclk,
    input  logic                         rst_n,
    input  logic                         vsync,
    input  logic [CHANNELS-1:0]          start,
    input  logic [CHANNELS-1:0]          stop,
    input  logic [CHANNELS*PERIOD_W-1:0] period,
    input  logic [CHANNELS*COUNT_W-1:0]  count,
    output logic                         frame_tick,
    output logic [CHANNELS-1:0]          tick,
    output logic [CHANNELS-1:0]          done,
    output logic [CHANNELS-1:0]          busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [PERIOD_W-1:0] PER_ONE = {{(PERIOD_W-1){1'b0}}, 1'b1};
    localparam logic [COUNT_W-1:0]  CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    // Shared vsync edge detector
    logic vsync_q;
    logic frame_tick_q;

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            vsync_q      <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            vsync_q      <= vsync;
            frame_tick_q <= vsync & ~vsync_q;
        end
    end

    assign frame_tick = frame_tick_q;

    // Per-channel schedulers
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        logic [0:0]          state_q, state_d;
        logic [PERIOD_W-1:0] phase_q, phase_d;
        logic [PERIOD_W-1:0] per_q, per_d;
        logic [COUNT_W-1:0]  rem_q, rem_d;
        logic                inf_q, inf_d;
        logic                tick_q, tick_d;
        logic                done_q, done_d;
        logic [PERIOD_W-1:0] period_i;
        logic [COUNT_W-1:0]  count_i;

        assign period_i = period[gi*PERIOD_W +: PERIOD_W];
        assign count_i  = count[gi*COUNT_W +: COUNT_W];

        always_comb begin
            state_d = state_q;
            phase_d = phase_q;
            per_d   = per_q;
            rem_d   = rem_q;
            inf_d   = inf_q;
            tick_d  = 1'b0;
            done_d  = 1'b0;

            if (stop[gi]) begin
                state_d = ST_IDLE;
                phase_d = '0;
            end else if (start[gi]) begin
                // Start and restart both reload the channel. A start that
                // lands on a frame_tick cycle does not count that frame.
                state_d = ST_RUN;
                phase_d = '0;
                per_d   = (period_i == '0) ? PER_ONE : period_i;
                rem_d   = count_i;
                inf_d   = (count_i == '0);
            end else if (state_q == ST_RUN && frame_tick_q) begin
                if (phase_q == per_q - PER_ONE) begin
                    phase_d = '0;
                    tick_d  = 1'b1;
                    if (!inf_q) begin
                        rem_d = rem_q - CNT_ONE;
                        if (rem_q == CNT_ONE) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end else begin
                    phase_d = phase_q + PER_ONE;
                end
            end
        end

        always_ff @(posedge pclk) begin
            if (!rst_n) begin
                state_q <= ST_IDLE;
                phase_q <= '0;
                per_q   <= PER_ONE;
                rem_q   <= '0;
                inf_q   <= 1'b0;
                tick_q  <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                phase_q <= phase_d;
                per_q   <= per_d;
                rem_q   <= rem_d;
                inf_q   <= inf_d;
                tick_q  <= tick_d;
                done_q  <= done_d;
            end
        end

        assign tick[gi] = tick_q;
        assign done[gi] = done_q;
        // busy drops in the same cycle as done, because both are registered
        // from the same edge.
        assign busy[gi] = (state_q == ST_RUN);
    end

endmodule
